// File: rtl/crypto_loader_pkg.sv
// Shared types and constants for the cipher input loader.
package crypto_loader_pkg;

   localparam int WORD_W = 32;
   localparam int KEY_W  = 256;
   localparam int DATA_W = 128;

   localparam logic SEL_KEY  = 1'b0;
   localparam logic SEL_DATA = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      KEY_LOAD  = 3'd1,
      READY     = 3'd2,
      DATA_LOAD = 3'd3,
      ISSUE     = 3'd4,
      WAIT      = 3'd5
   } state_e;

endpackage

// File: rtl/crypto_input_loader_word_packer.sv
// Word-serial shift-left assembler: first word ends up as the MSW.
module word_packer #(
   parameter int WORD_W = 32,
   parameter int N      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [WORD_W-1:0]     word_i,
   output logic [N*WORD_W-1:0]   value_o,
   output logic                  done_o
);

   localparam int W  = N * WORD_W;
   localparam int CW = $clog2(N + 1);

   logic [W-1:0]  shadow_q, shadow_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // value_o includes the word being loaded, so the owner can commit it on done_o
   assign value_o = {shadow_q[W-WORD_W-1:0], word_i};
   assign done_o  = load_i && (cnt_q == CW'(N - 1));

   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (clr_i || done_o) begin
         shadow_d = '0;
         cnt_d    = '0;
      end else if (load_i) begin
         shadow_d = value_o;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/crypto_input_loader.sv
// Key/data loader in front of the block cipher: locks the key, issues blocks, holds them until done.
module crypto_input_loader #(
   parameter int WORD_W     = crypto_loader_pkg::WORD_W,
   parameter int KEY_WORDS  = 8,
   parameter int DATA_WORDS = 4,
   parameter int KEY_W      = KEY_WORDS * WORD_W,
   parameter int DATA_W     = DATA_WORDS * WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_sel,
   input  logic              zeroize,
   input  logic              core_done,
   output logic [KEY_W-1:0]  key_out,
   output logic [DATA_W-1:0] data_out,
   output logic              start_out,
   output logic              key_loaded,
   output logic              busy,
   output logic              err
);

   import crypto_loader_pkg::state_e, crypto_loader_pkg::IDLE, crypto_loader_pkg::KEY_LOAD,
          crypto_loader_pkg::READY, crypto_loader_pkg::DATA_LOAD, crypto_loader_pkg::ISSUE,
          crypto_loader_pkg::WAIT, crypto_loader_pkg::SEL_KEY;

   state_e            state_q, state_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              kl_q, kl_d;
   logic              err_q, err_d;

   logic              accept, is_key, key_ld, dat_ld, bad;
   logic              key_done, dat_done;
   logic [KEY_W-1:0]  key_val;
   logic [DATA_W-1:0] dat_val;

   assign in_ready = !zeroize && (state_q == IDLE || state_q == KEY_LOAD ||
                                  state_q == READY || state_q == DATA_LOAD);
   assign accept   = in_valid && in_ready;
   assign is_key   = (in_sel == SEL_KEY);
   assign key_ld   = accept && is_key && (state_q == IDLE || state_q == KEY_LOAD);
   assign dat_ld   = accept && !is_key && (state_q == READY || state_q == DATA_LOAD);
   // Any accepted word that the current state does not want is dropped and flagged
   assign bad      = accept && !key_ld && !dat_ld;

   word_packer #(.WORD_W(WORD_W), .N(KEY_WORDS)) u_key_pack (
      .clk(clk), .rst(rst), .clr_i(zeroize), .load_i(key_ld), .word_i(in_word),
      .value_o(key_val), .done_o(key_done)
   );

   word_packer #(.WORD_W(WORD_W), .N(DATA_WORDS)) u_dat_pack (
      .clk(clk), .rst(rst), .clr_i(zeroize), .load_i(dat_ld), .word_i(in_word),
      .value_o(dat_val), .done_o(dat_done)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      data_d  = data_q;
      kl_d    = kl_q;
      err_d   = err_q | bad;
      if (zeroize) begin
         state_d = IDLE;
         key_d   = '0;
         data_d  = '0;
         kl_d    = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE, KEY_LOAD: begin
               if (key_done) begin
                  key_d   = key_val;
                  kl_d    = 1'b1;
                  state_d = READY;
               end else if (key_ld) begin
                  state_d = KEY_LOAD;
               end
            end
            READY, DATA_LOAD: begin
               if (dat_done) begin
                  data_d  = dat_val;
                  state_d = ISSUE;
               end else if (dat_ld) begin
                  state_d = DATA_LOAD;
               end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
               if (core_done) begin
                  data_d  = '0;
                  state_d = READY;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         data_q  <= '0;
         kl_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         data_q  <= data_d;
         kl_q    <= kl_d;
         err_q   <= err_d;
      end
   end

   assign key_out    = key_q;
   assign data_out   = data_q;
   assign key_loaded = kl_q;
   assign err        = err_q;
   assign start_out  = (state_q == ISSUE);
   assign busy       = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_crypto_input_loader.sv
// Directed bench for crypto_input_loader with a queue-based reference model.
module tb_crypto_input_loader;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_sel, zeroize, core_done;
   logic [31:0]   in_word;
   logic          in_ready, start_out, key_loaded, busy, err;
   logic [255:0]  key_out;
   logic [127:0]  data_out;

   int n_checks = 0;
   int n_fails  = 0;

   crypto_input_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .in_sel(in_sel), .zeroize(zeroize), .core_done(core_done), .key_out(key_out),
      .data_out(data_out), .start_out(start_out), .key_loaded(key_loaded), .busy(busy),
      .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: words collected in queues, block phase 0=none 1=issued 2=waiting
   logic [255:0] m_key;
   logic [127:0] m_data;
   bit           m_locked, m_err;
   int           m_blk;
   logic [31:0]  kq[$];
   logic [31:0]  dq[$];

   task automatic m_reset();
      m_key = '0; m_data = '0; m_locked = 0; m_err = 0; m_blk = 0;
      kq.delete(); dq.delete();
   endtask

   function automatic bit m_ready();
      return !zeroize && (m_blk == 0);
   endfunction

   task automatic m_update();
      if (rst || zeroize) m_reset();
      else if (m_blk == 1) m_blk = 2;
      else if (m_blk == 2) begin
         if (core_done) begin m_data = '0; m_blk = 0; end
      end else if (in_valid) begin
         if (in_sel == 1'b0) begin
            if (m_locked) m_err = 1;
            else begin
               kq.push_back(in_word);
               if (kq.size() == 8) begin
                  m_key = '0;
                  foreach (kq[i]) m_key = {m_key[223:0], kq[i]};
                  m_locked = 1;
                  kq.delete();
               end
            end
         end else begin
            if (!m_locked) m_err = 1;
            else begin
               dq.push_back(in_word);
               if (dq.size() == 4) begin
                  m_data = '0;
                  foreach (dq[i]) m_data = {m_data[95:0], dq[i]};
                  m_blk = 1;
                  dq.delete();
               end
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("in_ready",   256'(in_ready),   256'(m_ready()));
      check("key_out",    key_out,          m_key);
      check("data_out",   256'(data_out),   256'(m_data));
      check("start_out",  256'(start_out),  256'(m_blk == 1));
      check("busy",       256'(busy),       256'(m_blk != 0));
      check("key_loaded", 256'(key_loaded), 256'(m_locked));
      check("err",        256'(err),        256'(m_err));
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic send(input logic sel, input logic [31:0] w);
      in_valid = 1'b1; in_sel = sel; in_word = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic load_key(input logic [31:0] base);
      for (int i = 0; i < 8; i++) send(1'b0, base + 32'(i));
   endtask

   initial begin
      rst = 1'b1; in_valid = 0; in_sel = 0; zeroize = 0; core_done = 0; in_word = '0;
      m_reset();
      #2;
      check("rst_key", key_out, '0);
      check("rst_data", 256'(data_out), '0);
      check("rst_flags", 256'({start_out, key_loaded, busy, err, in_ready}), 256'(5'b00001));
      step(); step();
      rst = 1'b0;

      // data word with no key
      send(1'b1, 32'h55);
      check("idle_data_err", 256'({err, key_loaded}), 256'(2'b10));

      // zeroize clears err; the word offered alongside is refused
      zeroize = 1; in_valid = 1; in_sel = 0; in_word = 32'h9;
      step();
      zeroize = 0; in_valid = 0;
      check("zero_err_clr", 256'(err), '0);

      for (int i = 0; i < 8; i++) begin
         send(1'b0, 32'(i));
         if (i == 3) step();
      end
      check("key_value", key_out,
            256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);
      check("key_flags", 256'({key_loaded, in_ready}), 256'(2'b11));

      send(1'b0, 32'hFFFF_FFFF);
      check("key_locked_err", 256'(err), 256'(1));
      check("key_locked_val", key_out,
            256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007);

      for (int i = 0; i < 4; i++) send(1'b1, 32'hA0 + 32'(i));
      check("blk_data", 256'(data_out), 256'(128'h000000A0_000000A1_000000A2_000000A3));
      check("blk_start", 256'({start_out, in_ready, busy}), 256'(3'b101));
      step();
      check("blk_wait", 256'({start_out, busy}), 256'(2'b01));
      in_valid = 1; in_sel = 1; in_word = 32'hBB;
      repeat (15) step();
      core_done = 1;
      step();
      core_done = 0; in_valid = 0;
      check("blk_done", 256'({data_out, busy, in_ready}), 256'({128'h0, 2'b01}));
      check("blk_state", 256'(dut.state_q), 256'(crypto_loader_pkg::READY));

      // core_done during ISSUE must not end the block
      for (int i = 0; i < 4; i++) send(1'b1, 32'hB0 + 32'(i));
      core_done = 1;
      step();
      core_done = 0;
      check("issue_done_ign", 256'({busy, data_out}), 256'({1'b1, 128'h000000B0_000000B1_000000B2_000000B3}));
      repeat (3) step();
      core_done = 1;
      step();
      core_done = 0;
      check("blk2_done", 256'(busy), '0);

      // zeroize mid data load
      send(1'b1, 32'hC0);
      send(1'b1, 32'hC1);
      zeroize = 1;
      step();
      zeroize = 0;
      check("zero_all", 256'({key_out != 0, data_out != 0, start_out, key_loaded, busy, err}), '0);
      check("zero_state", 256'(dut.state_q), 256'(crypto_loader_pkg::IDLE));
      core_done = 1;
      step();
      core_done = 0;
      check("zero_done_ign", 256'({busy, key_loaded, in_ready}), 256'(3'b001));

      // asynchronous reset while waiting on the core
      load_key(32'h10);
      for (int i = 0; i < 4; i++) send(1'b1, 32'hD0 + 32'(i));
      step(); step(); step();
      check("pre_rst_busy", 256'(busy), 256'(1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_fly_out", 256'({busy, key_out != 0, data_out != 0, in_ready}), 256'(4'b0001));
      check("rst_fly_state", 256'(dut.state_q), 256'(crypto_loader_pkg::IDLE));
      m_reset();
      step();
      rst = 1'b0;

      // zeroize wins over a coincident core_done
      load_key(32'h20);
      for (int i = 0; i < 4; i++) send(1'b1, 32'hE0 + 32'(i));
      step();
      zeroize = 1; core_done = 1;
      step();
      zeroize = 0; core_done = 0;
      check("zero_vs_done", 256'(dut.state_q), 256'(crypto_loader_pkg::IDLE));
      check("zero_vs_done_kl", 256'({key_loaded, data_out != 0}), '0);
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
